// File: rtl/hmm_obs_gen.sv
// HMM observation generator: draws a hidden-state path and its emitted symbols from LFSR samples
// and streams them over a valid/ready handshake. Define HMM_GOLDEN_PATH_EN to add the golden_path port.
module hmm_obs_gen #(
  parameter int N  = 8,
  parameter int I  = 3,
  parameter int K  = 3,
  parameter int P  = 8,
  parameter int LW = $clog2(N),
  parameter int SW = $clog2(I),
  parameter int OW = $clog2(K)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LW-1:0]     length,
  input  logic [15:0]       seed,
  input  logic [I*P-1:0]    cumC,
  input  logic [I*I*P-1:0]  cumA,
  input  logic [I*K*P-1:0]  cumB,
  output logic [OW-1:0]     obs_out,
  output logic              obs_valid,
  input  logic              obs_ready,
  output logic              obs_first,
  output logic [SW-1:0]     state_out,
  output logic              busy,
`ifdef HMM_GOLDEN_PATH_EN
  output logic [N*SW-1:0]   golden_path,
`endif
  output logic              done
);

  // state | meaning
  // IDLE  | waiting for start
  // INIT  | draw initial hidden state from cumC
  // EMIT  | draw symbol from cumB row of current state, raise obs_valid
  // WAIT  | hold symbol until obs_ready handshake
  // TRANS | draw next hidden state from cumA row
  // DONE  | one-cycle done pulse, drop busy
  typedef enum logic [2:0] {S_IDLE, S_INIT, S_EMIT, S_WAIT, S_TRANS, S_DONE} fsm_t;

  fsm_t            fsm_q, fsm_nxt;
  logic [LW-1:0]   t_q, t_nxt;
  logic [LW-1:0]   len_q, len_nxt;
  logic [15:0]     lfsr_q, lfsr_nxt;
  logic [SW-1:0]   cur_q, cur_nxt;
  logic [OW-1:0]   obs_nxt;
  logic [SW-1:0]   state_out_nxt;
  logic            valid_nxt, first_nxt, busy_nxt, done_nxt;
  logic [P-1:0]    r;
  logic [I*P-1:0]  row_a;
  logic [K*P-1:0]  row_b;
`ifdef HMM_GOLDEN_PATH_EN
  logic [N*SW-1:0] golden_q, golden_nxt;
`endif

  function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  // Index = how many of the first n-1 thresholds the sample meets; last entry is never read.
  function automatic logic [SW-1:0] idx_i(input logic [P-1:0] rv, input logic [I*P-1:0] row);
    logic [SW-1:0] c;
    c = '0;
    for (int j = 0; j < I-1; j++)
      if (rv >= row[j*P +: P]) c = c + 1'b1;
    return c;
  endfunction

  function automatic logic [OW-1:0] idx_k(input logic [P-1:0] rv, input logic [K*P-1:0] row);
    logic [OW-1:0] c;
    c = '0;
    for (int j = 0; j < K-1; j++)
      if (rv >= row[j*P +: P]) c = c + 1'b1;
    return c;
  endfunction

  assign r     = lfsr_q[P-1:0];
  assign row_a = cumA[int'(cur_q)*I*P +: I*P];
  assign row_b = cumB[int'(cur_q)*K*P +: K*P];

  always_comb begin
    fsm_nxt       = fsm_q;
    t_nxt         = t_q;
    len_nxt       = len_q;
    lfsr_nxt      = lfsr_q;
    cur_nxt       = cur_q;
    obs_nxt       = obs_out;
    state_out_nxt = state_out;
    valid_nxt     = obs_valid;
    first_nxt     = obs_first;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
`ifdef HMM_GOLDEN_PATH_EN
    golden_nxt    = golden_q;
`endif
    case (fsm_q)
      S_IDLE: begin
        if (start) begin
          lfsr_nxt = (seed == 16'h0000) ? 16'h0001 : seed;
`ifdef HMM_GOLDEN_PATH_EN
          golden_nxt = '0;
`endif
          if (length != '0) begin
            len_nxt  = length;
            busy_nxt = 1'b1;
            fsm_nxt  = S_INIT;
          end else begin
            fsm_nxt  = S_DONE;
          end
        end
      end
      S_INIT: begin
        cur_nxt  = idx_i(r, cumC);
        t_nxt    = '0;
        lfsr_nxt = lfsr_adv(lfsr_q);
        fsm_nxt  = S_EMIT;
      end
      S_EMIT: begin
        obs_nxt       = idx_k(r, row_b);
        state_out_nxt = cur_q;
        first_nxt     = (t_q == '0);
        valid_nxt     = 1'b1;
        lfsr_nxt      = lfsr_adv(lfsr_q);
`ifdef HMM_GOLDEN_PATH_EN
        golden_nxt[int'(t_q)*SW +: SW] = cur_q;
`endif
        fsm_nxt       = S_WAIT;
      end
      S_WAIT: begin
        if (obs_valid && obs_ready) begin
          valid_nxt = 1'b0;
          first_nxt = 1'b0;
          fsm_nxt   = (t_q == len_q - 1'b1) ? S_DONE : S_TRANS;
        end
      end
      S_TRANS: begin
        cur_nxt  = idx_i(r, row_a);
        t_nxt    = t_q + 1'b1;
        lfsr_nxt = lfsr_adv(lfsr_q);
        fsm_nxt  = S_EMIT;
      end
      S_DONE: begin
        done_nxt = 1'b1;
        busy_nxt = 1'b0;
        fsm_nxt  = S_IDLE;
      end
      default: fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= S_IDLE;
      t_q       <= '0;
      len_q     <= '0;
      lfsr_q    <= 16'h0001;
      cur_q     <= '0;
      obs_out   <= '0;
      state_out <= '0;
      obs_valid <= 1'b0;
      obs_first <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef HMM_GOLDEN_PATH_EN
      golden_q  <= '0;
`endif
    end else begin
      fsm_q     <= fsm_nxt;
      t_q       <= t_nxt;
      len_q     <= len_nxt;
      lfsr_q    <= lfsr_nxt;
      cur_q     <= cur_nxt;
      obs_out   <= obs_nxt;
      state_out <= state_out_nxt;
      obs_valid <= valid_nxt;
      obs_first <= first_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
`ifdef HMM_GOLDEN_PATH_EN
      golden_q  <= golden_nxt;
`endif
    end
  end

`ifdef HMM_GOLDEN_PATH_EN
  assign golden_path = golden_q;
`endif

endmodule
